// File: rtl/fp_pkg.sv
// Shared definitions for the FPU add/subtract datapath:
// format defaults, operand classes and flag-vector layout.
package fp_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;

    localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        C_ZERO,
        C_NORM,
        C_INF,
        C_NAN
    } fp_class_e;

    localparam int FLG_OVF = 0;
    localparam int FLG_UNF = 1;
    localparam int FLG_INX = 2;
    localparam int FLG_INV = 3;
    localparam int FLG_W   = 4;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; returns W when the input is all zero.
module fp_lzc
    import fp_pkg::*;
#(
    parameter int W  = MAN_W_DEF + 4,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] cnt
);

    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i]) cnt = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754 style add/subtract with RNE rounding, flush-to-zero
// and valid/ready backpressure; the whole pipe stalls as one unit.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter  int EXP_W = EXP_W_DEF,
    parameter  int MAN_W = MAN_W_DEF,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] Data1,
    input  logic [W-1:0] Data2,
    input  logic         Sub_Op,
    input  logic         In_Data_Valid,
    output logic         In_Ready,
    output logic [W-1:0] Data_Out,
    output logic         Out_Valid,
    input  logic         Out_Ready,
    output logic         Flag_Ovf,
    output logic         Flag_Unf,
    output logic         Flag_Inexact,
    output logic         Flag_Invalid
);

    localparam int N  = MAN_W + 4;
    localparam int AW = MAN_W + 3;
    localparam int LW = $clog2(N + 1);
    localparam int XW = EXP_W + 2;
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic             vld;
        logic             spc;
        logic [W-1:0]     spc_res;
        logic [FLG_W-1:0] spc_flg;
        logic             sgn;
        logic [EXP_W-1:0] exp;
        logic             sub;
        logic             stk;
        logic [AW-1:0]    a_m;
        logic [AW-1:0]    b_m;
    } s1_t;

    typedef struct packed {
        logic             vld;
        logic             spc;
        logic [W-1:0]     spc_res;
        logic [FLG_W-1:0] spc_flg;
        logic             sgn;
        logic [EXP_W-1:0] exp;
        logic             stk;
        logic [N-1:0]     sum;
        logic [LW-1:0]    lz;
    } s2_t;

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e,
                                           input logic [MAN_W-1:0] f);
        if (e == '0) return C_ZERO;
        if (e != EMAX) return C_NORM;
        return (f == '0) ? C_INF : C_NAN;
    endfunction

    logic             adv;
    s1_t              s1_d, s1_q;
    s2_t              s2_d, s2_q;
    logic [FLG_W-1:0] flg_q;

    assign adv      = ~Out_Valid | Out_Ready;
    assign In_Ready = adv;

    // S1: classify, order by magnitude, align the smaller operand
    logic             a_s, b_s, swap, s_z;
    logic [EXP_W-1:0] a_e, b_e, l_e, s_e, diff;
    logic [MAN_W-1:0] a_f, b_f, l_f, s_f;
    logic [W-2:0]     a_mag, b_mag;
    fp_class_e        a_c, b_c;
    logic [31:0]      sh;
    logic [AW-1:0]    s_m;
    logic [2*AW-1:0]  al;

    assign a_s   = Data1[W-1];
    assign a_e   = Data1[W-2:MAN_W];
    assign a_f   = Data1[MAN_W-1:0];
    assign b_s   = Data2[W-1] ^ Sub_Op;
    assign b_e   = Data2[W-2:MAN_W];
    assign b_f   = Data2[MAN_W-1:0];
    assign a_c   = classify(a_e, a_f);
    assign b_c   = classify(b_e, b_f);
    assign a_mag = (a_c == C_ZERO) ? '0 : Data1[W-2:0];
    assign b_mag = (b_c == C_ZERO) ? '0 : Data2[W-2:0];
    assign swap  = b_mag > a_mag;

    always_comb begin
        s1_d     = '0;
        l_e      = swap ? b_e : a_e;
        l_f      = swap ? b_f : a_f;
        s_e      = swap ? a_e : b_e;
        s_f      = swap ? a_f : b_f;
        s_z      = swap ? (a_c == C_ZERO) : (b_c == C_ZERO);
        diff     = l_e - s_e;
        sh       = (32'(diff) >= 32'(AW)) ? 32'(AW) : 32'(diff);
        s_m      = s_z ? '0 : {1'b1, s_f, 2'b00};
        al       = {s_m, {AW{1'b0}}} >> sh;
        s1_d.vld = In_Data_Valid;
        s1_d.sgn = swap ? b_s : a_s;
        s1_d.exp = l_e;
        s1_d.sub = a_s ^ b_s;
        s1_d.a_m = {1'b1, l_f, 2'b00};
        s1_d.b_m = al[2*AW-1:AW];
        s1_d.stk = |al[AW-1:0];
        if (a_c == C_NAN || b_c == C_NAN) begin
            s1_d.spc              = 1'b1;
            s1_d.spc_res          = QNAN;
            s1_d.spc_flg[FLG_INV] = 1'b1;
        end else if (a_c == C_INF && b_c == C_INF) begin
            s1_d.spc = 1'b1;
            if (a_s == b_s) begin
                s1_d.spc_res = {a_s, EMAX, {MAN_W{1'b0}}};
            end else begin
                s1_d.spc_res          = QNAN;
                s1_d.spc_flg[FLG_INV] = 1'b1;
            end
        end else if (a_c == C_INF) begin
            s1_d.spc     = 1'b1;
            s1_d.spc_res = {a_s, EMAX, {MAN_W{1'b0}}};
        end else if (b_c == C_INF) begin
            s1_d.spc     = 1'b1;
            s1_d.spc_res = {b_s, EMAX, {MAN_W{1'b0}}};
        end else if (a_c == C_ZERO && b_c == C_ZERO) begin
            s1_d.spc     = 1'b1;
            s1_d.spc_res = {a_s & b_s, {(W-1){1'b0}}};
        end
    end

    // S2: add/sub; a set sticky on subtract borrows one from the R position
    logic [N-1:0]  sum_c;
    logic [LW-1:0] lz_c;

    always_comb begin
        if (s1_q.sub)
            sum_c = {1'b0, s1_q.a_m} - {1'b0, s1_q.b_m} - N'(s1_q.stk);
        else
            sum_c = {1'b0, s1_q.a_m} + {1'b0, s1_q.b_m};
    end

    fp_lzc #(.W(N), .CW(LW)) u_lzc (
        .din (sum_c),
        .cnt (lz_c)
    );

    always_comb begin
        s2_d         = '0;
        s2_d.vld     = s1_q.vld;
        s2_d.spc     = s1_q.spc;
        s2_d.spc_res = s1_q.spc_res;
        s2_d.spc_flg = s1_q.spc_flg;
        s2_d.sgn     = s1_q.sgn;
        s2_d.exp     = s1_q.exp;
        s2_d.stk     = s1_q.stk;
        s2_d.sum     = sum_c;
        s2_d.lz      = lz_c;
    end

    // S3: shifting by lz puts the hidden bit at the MSB (lz=0 on carry-out)
    logic [N-1:0]     norm;
    logic [MAN_W-1:0] frac, rf;
    logic             g, r, s, up, rc;
    logic [XW-1:0]    e_n, e_r;
    logic [W-1:0]     res_d;
    logic [FLG_W-1:0] flg_d;

    always_comb begin
        norm  = s2_q.sum << s2_q.lz;
        frac  = norm[N-2:3];
        g     = norm[2];
        r     = norm[1];
        s     = norm[0] | s2_q.stk;
        e_n   = {2'b00, s2_q.exp} + XW'(1) - XW'(s2_q.lz);
        up    = g & (r | s | frac[0]);
        {rc, rf} = {1'b0, frac} + {{MAN_W{1'b0}}, up};
        e_r   = e_n + XW'(rc);
        res_d = '0;
        flg_d = '0;
        if (s2_q.vld) begin
            if (s2_q.spc) begin
                res_d = s2_q.spc_res;
                flg_d = s2_q.spc_flg;
            end else if (!norm[N-1]) begin
                res_d = '0;
            end else if (e_n[XW-1] || e_n == '0) begin
                res_d          = {s2_q.sgn, {(W-1){1'b0}}};
                flg_d[FLG_UNF] = 1'b1;
                flg_d[FLG_INX] = 1'b1;
            end else if (e_r >= {2'b00, EMAX}) begin
                res_d          = {s2_q.sgn, EMAX, {MAN_W{1'b0}}};
                flg_d[FLG_OVF] = 1'b1;
                flg_d[FLG_INX] = 1'b1;
            end else begin
                res_d          = {s2_q.sgn, e_r[EXP_W-1:0], rf};
                flg_d[FLG_INX] = g | r | s;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            Out_Valid <= 1'b0;
            Data_Out  <= '0;
            flg_q     <= '0;
        end else if (adv) begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            Out_Valid <= s2_q.vld;
            Data_Out  <= res_d;
            flg_q     <= flg_d;
        end
    end

    assign Flag_Ovf     = flg_q[FLG_OVF];
    assign Flag_Unf     = flg_q[FLG_UNF];
    assign Flag_Inexact = flg_q[FLG_INX];
    assign Flag_Invalid = flg_q[FLG_INV];

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed-vector bench for fp_addsub_pipe (binary32 defaults).
module tb_fp_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] Data1 = '0;
    logic [31:0] Data2 = '0;
    logic        Sub_Op = 1'b0;
    logic        In_Data_Valid = 1'b0;
    logic        In_Ready;
    logic [31:0] Data_Out;
    logic        Out_Valid;
    logic        Out_Ready = 1'b1;
    logic        Flag_Ovf, Flag_Unf, Flag_Inexact, Flag_Invalid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_addsub_pipe dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Data1         (Data1),
        .Data2         (Data2),
        .Sub_Op        (Sub_Op),
        .In_Data_Valid (In_Data_Valid),
        .In_Ready      (In_Ready),
        .Data_Out      (Data_Out),
        .Out_Valid     (Out_Valid),
        .Out_Ready     (Out_Ready),
        .Flag_Ovf      (Flag_Ovf),
        .Flag_Unf      (Flag_Unf),
        .Flag_Inexact  (Flag_Inexact),
        .Flag_Invalid  (Flag_Invalid)
    );

    // flags packed as {invalid, inexact, unf, ovf}
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic sub, output logic [31:0] res,
                         output logic [3:0] flg, output int lat);
        @(negedge clk);
        Data1 = a;
        Data2 = b;
        Sub_Op = sub;
        In_Data_Valid = 1'b1;
        Out_Ready = 1'b1;
        @(negedge clk);
        In_Data_Valid = 1'b0;
        lat = 1;
        while (!Out_Valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!Out_Valid) lat = -1;
        res = Data_Out;
        flg = {Flag_Invalid, Flag_Inexact, Flag_Unf, Flag_Ovf};
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (Out_Valid !== 1'b0 || Data_Out !== 32'h0 ||
            {Flag_Invalid, Flag_Inexact, Flag_Unf, Flag_Ovf} !== 4'b0) begin
            errors++;
            $display("FAIL reset_state: valid %b data %h flags %b, want 0 0 0",
                     Out_Valid, Data_Out,
                     {Flag_Invalid, Flag_Inexact, Flag_Unf, Flag_Ovf});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (In_Ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", In_Ready);
        end
    endtask

    task automatic test_basic();
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        issue(32'h3F800000, 32'h3F800000, 1'b0, res, flg, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL latency: got %0d want 3", lat);
        end
        checks++;
        if (res !== 32'h40000000 || flg !== 4'b0000) begin
            errors++;
            $display("FAIL one_plus_one: got %h/%b want 40000000/0000", res, flg);
        end
    endtask

    task automatic test_zero();
        logic [31:0] va[4], vb[4], vr[4];
        logic        vs[4];
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        va = '{32'h3FC00000, 32'h80000000, 32'h40490FDB, 32'h3F800000};
        vb = '{32'h3FC00000, 32'h80000000, 32'h00000000, 32'h40000000};
        vs = '{1'b1, 1'b0, 1'b0, 1'b1};
        vr = '{32'h00000000, 32'h80000000, 32'h40490FDB, 32'hBF800000};
        for (int i = 0; i < 4; i++) begin
            issue(va[i], vb[i], vs[i], res, flg, lat);
            checks++;
            if (lat < 0 || res !== vr[i] || flg !== 4'b0000) begin
                errors++;
                $display("FAIL zero[%0d]: got %h/%b lat %0d want %h/0000",
                         i, res, flg, lat, vr[i]);
            end
        end
    endtask

    task automatic test_rounding();
        logic [31:0] va[5], vb[5], vr[5];
        logic        vs[5];
        logic [3:0]  vf[5];
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        va = '{32'h3F800000, 32'h3F800001, 32'h3F800000, 32'h3F800000, 32'h7F7FFFFF};
        vb = '{32'h33800000, 32'h33800000, 32'h00800000, 32'h00800000, 32'h7F7FFFFF};
        vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vr = '{32'h3F800000, 32'h3F800002, 32'h3F800000, 32'h3F800000, 32'h7F800000};
        vf = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0101};
        for (int i = 0; i < 5; i++) begin
            issue(va[i], vb[i], vs[i], res, flg, lat);
            checks++;
            if (lat < 0 || res !== vr[i] || flg !== vf[i]) begin
                errors++;
                $display("FAIL round[%0d]: got %h/%b lat %0d want %h/%b",
                         i, res, flg, lat, vr[i], vf[i]);
            end
        end
    endtask

    task automatic test_special();
        logic [31:0] va[6], vb[6], vr[6];
        logic        vs[6];
        logic [3:0]  vf[6];
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        va = '{32'h7F800000, 32'h7FC00001, 32'h7F800000,
               32'hFF800000, 32'h00800000, 32'h3F800000};
        vb = '{32'h7F800000, 32'h3F800000, 32'h3F800000,
               32'hFF800000, 32'h00800001, 32'hFF800000};
        vs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vr = '{32'h7FC00000, 32'h7FC00000, 32'h7F800000,
               32'hFF800000, 32'h80000000, 32'hFF800000};
        vf = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0110, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            issue(va[i], vb[i], vs[i], res, flg, lat);
            checks++;
            if (lat < 0 || res !== vr[i] || flg !== vf[i]) begin
                errors++;
                $display("FAIL special[%0d]: got %h/%b lat %0d want %h/%b",
                         i, res, flg, lat, vr[i], vf[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins[8], exp_r[8];
        logic [31:0] held;
        logic        stalled_prev;
        int          in_idx, out_idx, cyc;
        ins   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                  32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        exp_r = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                  32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
        in_idx = 0;
        out_idx = 0;
        cyc = 0;
        held = '0;
        stalled_prev = 1'b0;
        while ((in_idx < 8 || out_idx < 8) && cyc < 80) begin
            @(negedge clk);
            Out_Ready = !(cyc >= 6 && cyc < 11);
            In_Data_Valid = (in_idx < 8);
            Data1 = ins[in_idx % 8];
            Data2 = 32'h3F800000;
            Sub_Op = 1'b0;
            #1;
            if (Out_Valid && !Out_Ready) begin
                checks++;
                if (In_Ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_in_ready: cyc %0d got %b want 0", cyc, In_Ready);
                end
                if (stalled_prev) begin
                    checks++;
                    if (Data_Out !== held) begin
                        errors++;
                        $display("FAIL bp_hold: cyc %0d got %h want %h",
                                 cyc, Data_Out, held);
                    end
                end
                held = Data_Out;
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            if (Out_Valid && Out_Ready) begin
                checks++;
                if (Data_Out !== exp_r[out_idx]) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got %h want %h",
                             out_idx, Data_Out, exp_r[out_idx]);
                end
                out_idx++;
            end
            if (In_Data_Valid && In_Ready) in_idx++;
            cyc++;
        end
        @(negedge clk);
        In_Data_Valid = 1'b0;
        Out_Ready = 1'b1;
        checks++;
        if (in_idx != 8 || out_idx != 8) begin
            errors++;
            $display("FAIL bp_count: in %0d out %0d want 8 8", in_idx, out_idx);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (Out_Valid !== 1'b0 || Flag_Inexact !== 1'b0) begin
                errors++;
                $display("FAIL bp_extra: cyc %0d valid %b inexact %b want 0 0",
                         k, Out_Valid, Flag_Inexact);
            end
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        Out_Ready = 1'b1;
        In_Data_Valid = 1'b1;
        Data1 = 32'h3F800000;
        Data2 = 32'h3F800000;
        Sub_Op = 1'b0;
        @(negedge clk);
        Data1 = 32'h40000000;
        @(negedge clk);
        Data1 = 32'h40400000;
        @(negedge clk);
        In_Data_Valid = 1'b0;
        checks++;
        if (Out_Valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: valid %b want 1", Out_Valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (Out_Valid !== 1'b0 || Data_Out !== 32'h0 ||
            {Flag_Invalid, Flag_Inexact, Flag_Unf, Flag_Ovf} !== 4'b0) begin
            errors++;
            $display("FAIL rst_async: valid %b data %h want 0 0", Out_Valid, Data_Out);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (Out_Valid !== 1'b0 || In_Ready !== 1'b1) begin
                errors++;
                $display("FAIL rst_stale: cyc %0d valid %b ready %b want 0 1",
                         k, Out_Valid, In_Ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_rounding();
        test_special();
        test_back_to_back();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
